// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for hazard detection and the MD busy counter.
package pipe_pkg;

  typedef logic [4:0] reg_t;
  typedef logic [1:0] tuse_t;
  typedef logic [1:0] tnew_t;

  localparam int unsigned CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

  // Tuse value meaning the operand is not read at all
  localparam tuse_t TUSE_NONE = 2'd3;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // A source stalls when a younger-than-needed producer in E or M writes it
  function automatic logic src_stall(reg_t src, tuse_t tuse, reg_t e_a3, tnew_t e_tnew,
                                     reg_t m_a3, tnew_t m_tnew);
    return (src != '0) && (tuse != TUSE_NONE) &&
           (((e_a3 == src) && (e_tnew > tuse)) || ((m_a3 == src) && (m_tnew > tuse)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of D/E/M hazard inputs and pipeline strobe outputs of the stall controller.
import pipe_pkg::*;

interface hazard_stall_ctrl_if;
  reg_t  D_rs;
  reg_t  D_rt;
  tuse_t D_tuse_rs;
  tuse_t D_tuse_rt;
  logic  D_is_md;
  reg_t  E_A3;
  tnew_t E_tnew;
  reg_t  M_A3;
  tnew_t M_tnew;
  logic  E_md_start;
  logic  E_md_div;
  logic  PC_en;
  logic  FD_en;
  logic  DE_en;
  logic  DE_clr;
  logic  md_busy;
  logic  md_done;

  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md, E_A3, E_tnew, M_A3, M_tnew,
           E_md_start, E_md_div,
    input  PC_en, FD_en, DE_en, DE_clr, md_busy, md_done
  );

  modport slave (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md, E_A3, E_tnew, M_A3, M_tnew,
           E_md_start, E_md_div,
    output PC_en, FD_en, DE_en, DE_clr, md_busy, md_done
  );
endinterface

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// Multiply/divide busy counter: loads the op latency on start, counts down to idle.
module md_busy_counter
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  cnt_t cnt_q, cnt_d;

  // A new start reloads even while busy
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = is_div ? cnt_t'(DIV_CYCLES) : cnt_t'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign done = (cnt_q == cnt_t'(1));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: Tuse/Tnew data hazards plus MD-busy interlock.
module hazard_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic               clk,
  input logic               reset,
  hazard_stall_ctrl_if.slave bus
);

  logic rs_stall, rt_stall, md_stall, stall;

  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk   (clk),
    .reset (reset),
    .start (bus.E_md_start),
    .is_div(bus.E_md_div),
    .busy  (bus.md_busy),
    .done  (bus.md_done)
  );

  always_comb begin
    rs_stall = src_stall(bus.D_rs, bus.D_tuse_rs, bus.E_A3, bus.E_tnew, bus.M_A3, bus.M_tnew);
    rt_stall = src_stall(bus.D_rt, bus.D_tuse_rt, bus.E_A3, bus.E_tnew, bus.M_A3, bus.M_tnew);
    // An MD op entering E this cycle is not yet counted, so it stalls directly
    md_stall = bus.D_is_md & (bus.md_busy | bus.E_md_start);
    stall    = rs_stall | rt_stall | md_stall;
  end

  // D/E stays enabled; its clear takes priority and inserts the bubble
  assign bus.PC_en  = ~stall;
  assign bus.FD_en  = ~stall;
  assign bus.DE_en  = 1'b1;
  assign bus.DE_clr = stall;

endmodule
